// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the core-side fetch/data ports and the RAM-side
// request/response lines of the memory arbiter.
//   slave  : the arbiter (consumes requests and RAM status, drives waits/loads/strobes/err)
//   master : the environment (core + RAM) driving the other direction
// Port summary:
//   iREN/iaddr/iwait/iload               fetch port
//   dREN/dWEN/daddr/dstore/dwait/dload   data port
//   ramREN/ramWEN/ramaddr/ramstore       RAM request lines
//   ramload/ramstate                     RAM response (ramstate: FREE=0 BUSY=1 ACCESS=2 ERROR=3)
//   err                                  sticky error flag
interface mem_arbiter_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic        err;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported RAM between the fetch port and the
// data port. Data has priority; one access at a time with an IDLE bubble
// between accesses; a bounded timeout forces completion if the RAM hangs.
// Ports:
//   CLK  clock, rising edge
//   RST  synchronous reset, active-high
//   bus  mem_arbiter_if.slave (fetch port, data port, RAM lines, err)
// Parameters:
//   TIMEOUT     access cycles without ACCESS/ERROR before forced abort (>=2)
//   STARVE_MAX  consecutive data grants with fetch pending before fetch is forced
// Configuration macro:
//   ARB_STARVE_GUARD_EN  enables the fetch starvation guard (default: off,
//                        strict data priority)
module mem_arbiter #(
  parameter int TIMEOUT    = 16,
  parameter int STARVE_MAX = 4
) (
  input logic         CLK,
  input logic         RST,
  mem_arbiter_if.slave bus
);

  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;
  localparam logic [31:0] BAD_LOAD = 32'hBAD1BAD1;

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, D_ACC, I_ACC} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;

  logic d_req, done, abort, pick_i;

  assign d_req = bus.dREN | bus.dWEN;
  assign done  = (bus.ramstate == RS_ACCESS);
  assign abort = (bus.ramstate == RS_ERROR) | (tmo_q == TMAX);

`ifdef ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);
  logic [SW-1:0] starve_q, starve_d;

  // Fetch is forced only when it is actually pending.
  assign pick_i = bus.iREN & (starve_q == SMAX);

  always_ff @(posedge CLK) begin
    if (RST) starve_q <= '0;
    else     starve_q <= starve_d;
  end

  always_comb begin
    starve_d = starve_q;
    if (state_q == IDLE) begin
      if (pick_i || (!d_req && bus.iREN))
        starve_d = '0;
      else if (d_req && bus.iREN && starve_q != SMAX)
        starve_d = starve_q + 1'b1;
    end
  end
`else
  logic unused_starve;
  assign unused_starve = ^STARVE_MAX;
  assign pick_i = 1'b0;
`endif

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    // Both data strobes together is a protocol error even though it is serviced.
    err_d   = err_q | (bus.dREN & bus.dWEN);
    case (state_q)
      IDLE: begin
        tmo_d = '0;
        if (pick_i)        state_d = I_ACC;
        else if (d_req)    state_d = D_ACC;
        else if (bus.iREN) state_d = I_ACC;
      end
      D_ACC, I_ACC: begin
        if ((state_q == D_ACC) ? !d_req : !bus.iREN) begin
          state_d = IDLE;                    // withdrawal: no completion
        end else if (done) begin
          state_d = IDLE;
        end else if (abort) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          tmo_d = (tmo_q == TMAX) ? tmo_q : tmo_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic; completion is suppressed while RST is held so a reset
  // mid-access never produces a wait=0 pulse.
  always_comb begin
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    bus.iwait    = 1'b1;
    bus.iload    = '0;
    bus.dwait    = 1'b1;
    bus.dload    = '0;
    case (state_q)
      D_ACC: begin
        bus.ramaddr  = bus.daddr;
        bus.ramstore = bus.dstore;
        bus.ramWEN   = bus.dWEN;
        bus.ramREN   = bus.dREN & ~bus.dWEN;
        if (d_req && !RST) begin
          if (done) begin
            bus.dwait = 1'b0;
            if (bus.dREN && !bus.dWEN) bus.dload = bus.ramload;
          end else if (abort) begin
            bus.dwait = 1'b0;
            bus.dload = BAD_LOAD;
          end
        end
      end
      I_ACC: begin
        bus.ramaddr = bus.iaddr;
        bus.ramREN  = bus.iREN;
        if (bus.iREN && !RST) begin
          if (done) begin
            bus.iwait = 1'b0;
            bus.iload = bus.ramload;
          end else if (abort) begin
            bus.iwait = 1'b0;
            bus.iload = BAD_LOAD;
          end
        end
      end
      default: ;
    endcase
  end

  assign bus.err = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  logic CLK = 1'b0;
  logic RST;
  int   n_chk = 0;
  int   n_err = 0;

  mem_arbiter_if bus();

  mem_arbiter #(.TIMEOUT(16), .STARVE_MAX(4)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACC = 2'd2, ERR = 2'd3;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; then inputs may change.
  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle;
    #1;
  endtask

  initial begin
    RST = 1'b1;
    bus.iREN = 0; bus.iaddr = 0; bus.dREN = 0; bus.dWEN = 0;
    bus.daddr = 0; bus.dstore = 0; bus.ramload = 0; bus.ramstate = FREE;
    step; step;
    settle;
    chk("rst_iwait",  32'(bus.iwait),  32'd1);
    chk("rst_dwait",  32'(bus.dwait),  32'd1);
    chk("rst_ramREN", 32'(bus.ramREN), 32'd0);
    chk("rst_ramWEN", 32'(bus.ramWEN), 32'd0);
    chk("rst_ramaddr", bus.ramaddr,    32'd0);
    chk("rst_iload",  bus.iload,       32'd0);
    chk("rst_err",    32'(bus.err),    32'd0);
    RST = 1'b0;

    // 1: fetch only, two BUSY cycles then ACCESS
    bus.iREN = 1; bus.iaddr = 32'h40; bus.ramstate = BUSY;
    settle;
    chk("t1_c0_ramREN", 32'(bus.ramREN), 32'd0);
    step; settle;
    chk("t1_c1_ramREN",  32'(bus.ramREN), 32'd1);
    chk("t1_c1_ramaddr", bus.ramaddr, 32'h40);
    chk("t1_c1_iwait",   32'(bus.iwait), 32'd1);
    step; settle;
    chk("t1_c2_iwait",   32'(bus.iwait), 32'd1);
    step;
    bus.ramstate = ACC; bus.ramload = 32'h8C220004;
    settle;
    chk("t1_c3_iwait", 32'(bus.iwait), 32'd0);
    chk("t1_c3_iload", bus.iload, 32'h8C220004);
    step;
    bus.iREN = 0; bus.ramstate = FREE;
    settle;
    chk("t1_c4_iwait",  32'(bus.iwait), 32'd1);
    chk("t1_c4_ramREN", 32'(bus.ramREN), 32'd0);

    // 2: simultaneous write and fetch; data first, bubble, then fetch
    bus.dWEN = 1; bus.daddr = 32'h100; bus.dstore = 32'hCAFE0001;
    bus.iREN = 1; bus.iaddr = 32'h44; bus.ramstate = BUSY;
    step; settle;
    chk("t2_ramWEN",   32'(bus.ramWEN), 32'd1);
    chk("t2_ramREN",   32'(bus.ramREN), 32'd0);
    chk("t2_ramaddr",  bus.ramaddr, 32'h100);
    chk("t2_ramstore", bus.ramstore, 32'hCAFE0001);
    bus.ramstate = ACC;
    settle;
    chk("t2_dwait", 32'(bus.dwait), 32'd0);
    chk("t2_iwait_during_d", 32'(bus.iwait), 32'd1);
    step;
    bus.dWEN = 0; bus.ramstate = BUSY;
    settle;
    chk("t2_bubble_ramREN",  32'(bus.ramREN), 32'd0);
    chk("t2_bubble_ramaddr", bus.ramaddr, 32'd0);
    chk("t2_bubble_iwait",   32'(bus.iwait), 32'd1);
    step; settle;
    chk("t2_i_ramREN",  32'(bus.ramREN), 32'd1);
    chk("t2_i_ramaddr", bus.ramaddr, 32'h44);
    bus.ramstate = ACC; bus.ramload = 32'h00001234;
    settle;
    chk("t2_i_iwait", 32'(bus.iwait), 32'd0);
    chk("t2_i_iload", bus.iload, 32'h00001234);
    step;
    bus.iREN = 0; bus.ramstate = FREE;
    settle;
    chk("t2_err", 32'(bus.err), 32'd0);

    // 3: RAM stuck BUSY -> forced completion on the 16th access cycle
    bus.dREN = 1; bus.daddr = 32'h200; bus.ramstate = BUSY;
    step;
    for (int k = 1; k <= 16; k++) begin
      settle;
      if (k < 16) begin
        chk($sformatf("t3_wait_%0d", k), 32'(bus.dwait), 32'd1);
      end else begin
        chk("t3_dwait", 32'(bus.dwait), 32'd0);
        chk("t3_dload", bus.dload, 32'hBAD1BAD1);
        chk("t3_err_before", 32'(bus.err), 32'd0);
      end
      step;
    end
    bus.dREN = 0; bus.ramstate = FREE;
    settle;
    chk("t3_err_set", 32'(bus.err), 32'd1);
    step; step; settle;
    chk("t3_err_sticky", 32'(bus.err), 32'd1);
    RST = 1; step; RST = 0; settle;
    chk("t3_err_cleared", 32'(bus.err), 32'd0);

    // 4a: withdrawal in 2nd D_ACC cycle
    bus.dREN = 1; bus.daddr = 32'h300; bus.ramstate = BUSY;
    step; settle;
    chk("t4_c1_ramREN", 32'(bus.ramREN), 32'd1);
    step;
    bus.dREN = 0;
    settle;
    chk("t4_c2_ramREN", 32'(bus.ramREN), 32'd0);
    chk("t4_c2_dwait",  32'(bus.dwait), 32'd1);
    step; settle;
    chk("t4_idle_ramaddr", bus.ramaddr, 32'd0);
    chk("t4_idle_dwait",   32'(bus.dwait), 32'd1);
    chk("t4_err",          32'(bus.err), 32'd0);

    // 4b: reset in the middle of I_ACC
    bus.iREN = 1; bus.iaddr = 32'h80;
    step; settle;
    chk("t4_i_ramREN", 32'(bus.ramREN), 32'd1);
    RST = 1;
    step; settle;
    chk("t4_rst_ramREN",  32'(bus.ramREN), 32'd0);
    chk("t4_rst_ramaddr", bus.ramaddr, 32'd0);
    chk("t4_rst_iwait",   32'(bus.iwait), 32'd1);
    chk("t4_rst_err",     32'(bus.err), 32'd0);
    RST = 0; bus.iREN = 0; bus.ramstate = FREE;
    step;

    // 5: back-to-back data with fetch pending throughout
    bus.iREN = 1; bus.iaddr = 32'h500; bus.ramstate = ACC; bus.ramload = 32'h0;
    for (int g = 1; g <= 5; g++) begin
      logic [31:0] exp_addr;
      logic        exp_iw;
      bus.dREN = 1; bus.daddr = 32'h600 + 32'(g);
`ifdef ARB_STARVE_GUARD_EN
      exp_addr = (g == 5) ? 32'h500 : 32'h600 + 32'(g);
      exp_iw   = (g == 5) ? 1'b0 : 1'b1;
`else
      exp_addr = 32'h600 + 32'(g);
      exp_iw   = 1'b1;
`endif
      settle;
      chk($sformatf("t5_idle_iwait_%0d", g), 32'(bus.iwait), 32'd1);
      step; settle;
      chk($sformatf("t5_grant_%0d", g), bus.ramaddr, exp_addr);
      chk($sformatf("t5_iwait_%0d", g), 32'(bus.iwait), 32'(exp_iw));
      step;
    end
    bus.dREN = 0; bus.iREN = 0; bus.ramstate = FREE;
    step;

    // 6: data read answered with ERROR, then a normal read
    bus.dREN = 1; bus.daddr = 32'h700; bus.ramstate = ERR;
    step; settle;
    chk("t6_dwait", 32'(bus.dwait), 32'd0);
    chk("t6_dload", bus.dload, 32'hBAD1BAD1);
    chk("t6_err_before", 32'(bus.err), 32'd0);
    step;
    bus.dREN = 0; bus.ramstate = FREE;
    settle;
    chk("t6_err", 32'(bus.err), 32'd1);
    bus.dREN = 1; bus.daddr = 32'h704; bus.ramstate = ACC; bus.ramload = 32'h55AA55AA;
    step; settle;
    chk("t6_next_ramaddr", bus.ramaddr, 32'h704);
    chk("t6_next_dwait", 32'(bus.dwait), 32'd0);
    chk("t6_next_dload", bus.dload, 32'h55AA55AA);
    step;
    bus.dREN = 0; bus.ramstate = FREE;
    settle;
    chk("t6_err_sticky", 32'(bus.err), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
